// File: rtl/snn_spike_readout_master_pkg.sv
// Shared constants for the spike readout master: FSM state codes, counter saturation
// value, word address stride and the ack timeout limit.
package snn_readout_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_ACC  = 3'd2;
    localparam logic [2:0] ST_SCAN = 3'd3;
    localparam logic [2:0] ST_RES  = 3'd4;

    localparam int         CNT_W_DEF     = 8;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};
    localparam int         WORD_STRIDE   = 8;
    localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/snn_spike_counter_bank.sv
// Bank of per-neuron saturating spike counters: parallel increment, bulk clear,
// and one combinational read port used by the winner scan.
module snn_spike_counter_bank #(
    parameter int NUM_NEURONS = 64,
    parameter int CNT_W       = 8,
    parameter int IDX_W       = 6
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   clear,
    input  logic [NUM_NEURONS-1:0] inc,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [CNT_W-1:0]       rd_cnt
);

    localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_reg [NUM_NEURONS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_cnt
            always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
                if (wb_rst_i) begin
                    cnt_reg[gi] <= '0;
                end else if (clear) begin
                    cnt_reg[gi] <= '0;
                end else if (inc[gi] && (cnt_reg[gi] != SAT)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign rd_cnt = cnt_reg[rd_idx];

endmodule

// File: rtl/snn_spike_readout_master.sv
// Wishbone initiator that reads the spike-output store each timestep, accumulates spikes
// per neuron and reports the argmax neuron after a sample. Option macro: SNN_RD_TIMEOUT_EN.
module snn_spike_readout_master
    import snn_readout_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          NUM_NEURONS = 64,
    parameter int          NUM_WORDS   = 2,
    parameter int          CNT_W       = 8,
    parameter int          IDX_W       = 6
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             step_i,
    input  logic             last_i,
    input  logic             clear_i,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i,
    output logic             busy_o,
    output logic             step_done_o,
    output logic             result_valid_o,
    output logic [IDX_W-1:0] winner_o,
    output logic [CNT_W-1:0] winner_cnt_o,
    output logic             err_o
);

    localparam int               WI_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [WI_W-1:0]  LAST_WORD = WI_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NEURONS - 1);

    logic [2:0]             state_reg;
    logic [WI_W-1:0]        word_idx_reg;
    logic                   last_reg;
    logic [31:0]            data_reg;
    logic [IDX_W-1:0]       scan_idx_reg;
    logic [IDX_W-1:0]       best_idx_reg;
    logic [CNT_W-1:0]       best_cnt_reg;
    logic [IDX_W-1:0]       winner_reg;
    logic [CNT_W-1:0]       winner_cnt_reg;
    logic                   step_done_reg;
    logic                   result_valid_reg;
    logic                   in_req;
    logic                   req_done;
    logic [31:0]            req_data;
    logic [NUM_NEURONS-1:0] inc_vec;
    logic                   bank_clear;
    logic [CNT_W-1:0]       rd_cnt;

    assign in_req = (state_reg == ST_REQ);

`ifdef SNN_RD_TIMEOUT_EN
    logic [7:0] to_cnt_reg;
    logic       err_reg;
    logic       timeout;

    // The 255th REQ cycle without an ack ends the read with zero data.
    assign timeout = in_req && !wbm_ack_i && (to_cnt_reg == TIMEOUT_LIMIT - 8'd1);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (in_req && !wbm_ack_i && !timeout) begin
                to_cnt_reg <= to_cnt_reg + 8'd1;
            end else begin
                to_cnt_reg <= '0;
            end
            if (timeout) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign req_done = in_req && (wbm_ack_i || timeout);
    assign req_data = wbm_ack_i ? wbm_dat_i : 32'h0;
    assign err_o    = err_reg;
`else
    assign req_done = in_req && wbm_ack_i;
    assign req_data = wbm_dat_i;
    assign err_o    = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg        <= ST_IDLE;
            word_idx_reg     <= '0;
            last_reg         <= 1'b0;
            data_reg         <= '0;
            scan_idx_reg     <= '0;
            best_idx_reg     <= '0;
            best_cnt_reg     <= '0;
            winner_reg       <= '0;
            winner_cnt_reg   <= '0;
            step_done_reg    <= 1'b0;
            result_valid_reg <= 1'b0;
        end else begin
            step_done_reg    <= 1'b0;
            result_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!clear_i && step_i) begin
                        last_reg     <= last_i;
                        word_idx_reg <= '0;
                        state_reg    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_done) begin
                        data_reg  <= req_data;
                        state_reg <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (word_idx_reg != LAST_WORD) begin
                        word_idx_reg <= word_idx_reg + 1'b1;
                        state_reg    <= ST_REQ;
                    end else begin
                        step_done_reg <= 1'b1;
                        scan_idx_reg  <= '0;
                        best_idx_reg  <= '0;
                        best_cnt_reg  <= '0;
                        state_reg     <= last_reg ? ST_SCAN : ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (rd_cnt > best_cnt_reg) begin
                        best_cnt_reg <= rd_cnt;
                        best_idx_reg <= scan_idx_reg;
                    end
                    scan_idx_reg <= scan_idx_reg + 1'b1;
                    if (scan_idx_reg == LAST_IDX) begin
                        state_reg <= ST_RES;
                    end
                end
                ST_RES: begin
                    winner_reg       <= best_idx_reg;
                    winner_cnt_reg   <= best_cnt_reg;
                    result_valid_reg <= 1'b1;
                    state_reg        <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_inc
            assign inc_vec[gi] = (state_reg == ST_ACC)
                               && (word_idx_reg == WI_W'(gi / 32))
                               && data_reg[gi % 32];
        end
    endgenerate

    assign bank_clear = ((state_reg == ST_IDLE) && clear_i) || (state_reg == ST_RES);

    snn_spike_counter_bank #(
        .NUM_NEURONS (NUM_NEURONS),
        .CNT_W       (CNT_W),
        .IDX_W       (IDX_W)
    ) u_bank (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clear    (bank_clear),
        .inc      (inc_vec),
        .rd_idx   (scan_idx_reg),
        .rd_cnt   (rd_cnt)
    );

    assign wbm_cyc_o      = in_req;
    assign wbm_stb_o      = in_req;
    assign wbm_we_o       = 1'b0;
    assign wbm_sel_o      = 4'hF;
    assign wbm_dat_o      = 32'h0;
    assign wbm_adr_o      = in_req ? (BASE_ADDR + 32'(word_idx_reg) * 32'(WORD_STRIDE)) : 32'h0;
    assign busy_o         = (state_reg != ST_IDLE);
    assign step_done_o    = step_done_reg;
    assign result_valid_o = result_valid_reg;
    assign winner_o       = winner_reg;
    assign winner_cnt_o   = winner_cnt_reg;

endmodule

// File: tb/tb_snn_spike_readout_master.sv
// Directed bench for snn_spike_readout_master: single-cycle-ack slave, spike-count model
// with argmax, per-cycle output compare plus literal winner expectations.
module tb_snn_spike_readout_master;

    localparam int          NN   = 64;
    localparam int          NW   = 2;
    localparam int          CW   = 8;
    localparam int          IW   = 6;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic          step_i, last_i, clear_i;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic [31:0]   wbm_adr_o, wbm_dat_o;
    logic          wbm_ack_i;
    logic [31:0]   wbm_dat_i;
    logic          busy_o, step_done_o, result_valid_o, err_o;
    logic [IW-1:0] winner_o;
    logic [CW-1:0] winner_cnt_o;

    int          total = 0;
    int          bad   = 0;
    int          reads;
    int          model_cnt [NN];
    logic [31:0] rd_data_q [$];
    logic [31:0] adr_log   [$];
    bit          pend = 0;
    int          pend_w, pend_c;
    int          held_w = 0;
    int          held_c = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    snn_spike_readout_master dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .step_i         (step_i),
        .last_i         (last_i),
        .clear_i        (clear_i),
        .wbm_cyc_o      (wbm_cyc_o),
        .wbm_stb_o      (wbm_stb_o),
        .wbm_we_o       (wbm_we_o),
        .wbm_sel_o      (wbm_sel_o),
        .wbm_adr_o      (wbm_adr_o),
        .wbm_dat_o      (wbm_dat_o),
        .wbm_ack_i      (wbm_ack_i),
        .wbm_dat_i      (wbm_dat_i),
        .busy_o         (busy_o),
        .step_done_o    (step_done_o),
        .result_valid_o (result_valid_o),
        .winner_o       (winner_o),
        .winner_cnt_o   (winner_cnt_o),
        .err_o          (err_o)
    );

    // Slave: acks one cycle after cyc&stb, returns queued data words in order.
    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbm_ack_i <= 1'b0;
            wbm_dat_i <= 32'h0;
            reads     <= 0;
        end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
            wbm_ack_i <= 1'b1;
            wbm_dat_i <= (rd_data_q.size() > 0) ? rd_data_q.pop_front() : 32'h0;
            adr_log.push_back(wbm_adr_o);
            reads     <= reads + 1;
        end else begin
            wbm_ack_i <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void model_add(input logic [31:0] d, input int r);
        for (int k = 0; k < 32; k++) begin
            if (d[k] && model_cnt[32*r+k] < 255) model_cnt[32*r+k]++;
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NN; i++) model_cnt[i] = 0;
    endfunction

    function automatic void model_result(output int w, output int c);
        w = 0;
        c = 0;
        for (int i = 0; i < NN; i++) begin
            if (model_cnt[i] > c) begin
                c = model_cnt[i];
                w = i;
            end
        end
    endfunction

    // Per-cycle compare: bus constants, request address, and held/updated winner outputs.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            chk("bus_const", {wbm_we_o, wbm_sel_o, wbm_dat_o, wbm_stb_o},
                {1'b0, 4'hF, 32'h0, wbm_cyc_o});
            if (wbm_cyc_o && !wbm_ack_i)
                chk("req_adr", wbm_adr_o, BASE + 32'(8 * (reads % NW)));
            if (result_valid_o) begin
                if (!pend) begin
                    chk("spurious_result", 1, 0);
                end else begin
                    held_w = pend_w;
                    held_c = pend_c;
                    pend   = 0;
                end
            end
            chk("winner_hold", {winner_o, winner_cnt_o}, {IW'(held_w), CW'(held_c)});
            chk("err_flag", err_o, 0);
        end
    end

    // Called at a negedge; returns at a negedge with the DUT idle again.
    task automatic do_step(input logic [31:0] d0, input logic [31:0] d1, input bit last);
        int n;
        int m;
        int w;
        int c;
        rd_data_q.push_back(d0);
        rd_data_q.push_back(d1);
        step_i = 1'b1;
        last_i = last;
        @(negedge wb_clk_i);
        step_i = 1'b0;
        last_i = 1'b0;
        n = 0;
        while (!step_done_o && n < 100) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("step_latency", n, 6);
        model_add(d0, 0);
        model_add(d1, 1);
        if (last) begin
            model_result(w, c);
            pend_w = w;
            pend_c = c;
            pend   = 1;
            model_clear();
        end
        @(negedge wb_clk_i);
        chk("step_done_pulse", step_done_o, 0);
        if (last) begin
            m = 1;
            while (!result_valid_o && m < 200) begin
                @(negedge wb_clk_i);
                m++;
            end
            chk("result_latency", m, NN + 1);
        end
    endtask

    task automatic expect_winner(input string name, input int w, input int c);
        chk({name, "_winner"}, winner_o, w);
        chk({name, "_count"}, winner_cnt_o, c);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int n;
        model_clear();
        wb_rst_i = 1'b1;
        step_i   = 1'b0;
        last_i   = 1'b0;
        clear_i  = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        chk("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_adr_o}, 0);
        chk("rst_status", {busy_o, step_done_o, result_valid_o, err_o}, 0);
        chk("rst_winner", {winner_o, winner_cnt_o}, 0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // Basic read: n0 and n63 get one spike each.
        adr_log.delete();
        do_step(32'h0000_0001, 32'h8000_0000, 1'b0);
        chk("basic_reads", adr_log.size(), 2);
        if (adr_log.size() >= 2) begin
            chk("basic_adr0", adr_log[0], 32'h3000_0000);
            chk("basic_adr1", adr_log[1], 32'h3000_0008);
        end
        do_step(32'h0, 32'h8000_0000, 1'b1);
        expect_winner("basic", 63, 2);

        // Neuron 5 spikes 3x, neuron 40 2x.
        do_step(32'h0000_0020, 32'h0000_0100, 1'b0);
        do_step(32'h0000_0020, 32'h0000_0100, 1'b0);
        do_step(32'h0000_0020, 32'h0, 1'b1);
        expect_winner("select", 5, 3);

        // Counters were cleared by the previous result.
        do_step(32'h0, 32'h0, 1'b1);
        expect_winner("zero", 0, 0);

        // Tie between neurons 10 and 20, neuron 63 just behind.
        for (int s = 0; s < 4; s++)
            do_step(32'h0010_0400, (s < 3) ? 32'h8000_0000 : 32'h0, s == 3);
        expect_winner("tie", 10, 4);

        for (int s = 1; s <= 300; s++)
            do_step(32'hFFFF_FFFF, 32'hFFFF_FFFF, s == 300);
        expect_winner("sat", 0, 255);

        // step_i during REQ is dropped.
        r0 = reads;
        rd_data_q.push_back(32'h0);
        rd_data_q.push_back(32'h0);
        step_i = 1'b1;
        @(negedge wb_clk_i);
        chk("busy_in_req", busy_o, 1);
        last_i = 1'b1;
        @(negedge wb_clk_i);
        step_i = 1'b0;
        last_i = 1'b0;
        n = 0;
        while (!step_done_o && n < 100) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("busy_step_done_seen", step_done_o, 1);
        repeat (10) @(negedge wb_clk_i);
        chk("busy_reads", reads - r0, 2);
        chk("busy_idle", busy_o, 0);

        // clear_i with step_i: counters wiped, no bus cycle.
        do_step(32'hFFFF_FFFF, 32'h0, 1'b0);
        r0 = reads;
        clear_i = 1'b1;
        step_i  = 1'b1;
        last_i  = 1'b1;
        @(negedge wb_clk_i);
        clear_i = 1'b0;
        step_i  = 1'b0;
        last_i  = 1'b0;
        model_clear();
        repeat (8) @(negedge wb_clk_i);
        chk("clear_no_reads", reads - r0, 0);
        chk("clear_idle", busy_o, 0);
        do_step(32'h0, 32'h0, 1'b1);
        expect_winner("clear", 0, 0);

        // Reset while a read is outstanding.
        do_step(32'h0, 32'h0000_0004, 1'b0);
        rd_data_q.push_back(32'hFFFF_FFFF);
        rd_data_q.push_back(32'hFFFF_FFFF);
        step_i = 1'b1;
        @(negedge wb_clk_i);
        step_i = 1'b0;
        chk("pre_rst_cyc", wbm_cyc_o, 1);
        #2;
        wb_rst_i = 1'b1;
        #1;
        chk("rst_mid_cyc", {wbm_cyc_o, wbm_stb_o}, 0);
        chk("rst_mid_busy", busy_o, 0);
        @(negedge wb_clk_i);
        rd_data_q.delete();
        model_clear();
        pend   = 0;
        held_w = 0;
        held_c = 0;
        wb_rst_i = 1'b0;
        repeat (5) @(negedge wb_clk_i);
        chk("post_rst_reads", reads, 0);
        chk("post_rst_cyc", wbm_cyc_o, 0);
        do_step(32'h0, 32'h0, 1'b1);
        expect_winner("post_rst", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
